// File: rtl/serial_compare.sv
// Bit-serial magnitude comparator: consumes one (a,b) bit pair per transfer and reports A>B / A==B / A<B.
// Build option: define SERIAL_CMP_LSB_FIRST_EN for LSB-first operands (last differing bit decides).
module serial_compare #(
    parameter int MAX_BITS = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic a,
    input  logic b,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic trunc
);

    localparam int CW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_BITS - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_GT   = 2'd1,
        DEC_LT   = 2'd2
    } decision_t;

    state_t    state_q, state_d;
    decision_t dec_q, dec_d;
    logic [CW-1:0] count_q, count_d;
    logic      trunc_q, trunc_d;

    logic      transfer;
    logic      atLimit;

    assign transfer = in_valid && in_ready;
    assign atLimit  = (count_q == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            dec_q   <= DEC_NONE;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        count_d = count_q;
        trunc_d = trunc_q;
        unique case (state_q)
            S_RUN: begin
                if (transfer) begin
                    if (a != b) begin
`ifdef SERIAL_CMP_LSB_FIRST_EN
                        dec_d = a ? DEC_GT : DEC_LT;
`else
                        if (dec_q == DEC_NONE) begin
                            dec_d = a ? DEC_GT : DEC_LT;
                        end
`endif
                    end
                    // The counter stops at the limit; reaching it ends the operand either way.
                    if (in_last || atLimit) begin
                        state_d = S_DONE;
                        trunc_d = !in_last;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_RUN;
                    dec_d   = DEC_NONE;
                    count_d = '0;
                    trunc_d = 1'b0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign in_ready  = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign out1      = out_valid && (dec_q == DEC_GT);
    assign out2      = out_valid && (dec_q == DEC_NONE);
    assign out3      = out_valid && (dec_q == DEC_LT);
    assign trunc     = out_valid && trunc_q;

endmodule

// File: tb/tb_serial_compare.sv
// Directed and randomized bench for serial_compare; expected results come from a queue-based scoreboard.
// Honours SERIAL_CMP_LSB_FIRST_EN when computing expected decisions.
module tb_serial_compare;

    localparam int MAX_BITS = 32;

    typedef struct packed {
        logic o1;
        logic o2;
        logic o3;
        logic tr;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out1, out2, out3, trunc;

    res_t expQ[$];
    int   total = 0;
    int   bad = 0;

    serial_compare #(.MAX_BITS(MAX_BITS)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out1(out1),
        .out2(out2),
        .out3(out3),
        .trunc(trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: bits are given in arrival order, element n-1 first.
    function automatic res_t model(input logic [1023:0] av, input logic [1023:0] bv,
                                   input int n, input bit last);
        res_t r;
        int   dec = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (av[i] != bv[i]) begin
`ifdef SERIAL_CMP_LSB_FIRST_EN
                dec = av[i] ? 1 : 2;
`else
                if (dec == 0) dec = av[i] ? 1 : 2;
`endif
            end
        end
        r.o1 = (dec == 1);
        r.o2 = (dec == 0);
        r.o3 = (dec == 2);
        r.tr = (!last && n == MAX_BITS);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string tag, input logic [1023:0] av, input logic [1023:0] bv,
                                 input int n, input bit last);
        chk({tag, "_ready"}, {7'b0, in_ready}, 8'b1);
        expQ.push_back(model(av, bv, n, last));
        for (int i = n - 1; i >= 0; i--) begin
            in_valid = 1'b1;
            a        = av[i];
            b        = bv[i];
            in_last  = (i == 0) && last;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        res_t exp;
        chk({tag, "_valid"}, {6'b0, out_valid, in_ready}, 8'b10);
        if (expQ.size() == 0) begin
            chk({tag, "_queue"}, 8'd0, 8'd1);
        end else begin
            exp = expQ.pop_front();
            chk({tag, "_res"}, {4'b0, out1, out2, out3, trunc}, {4'b0, exp});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {2'b0, out_valid, in_ready, out1, out2, out3, trunc}, 8'b0001_0000);
    endtask

    initial begin
        logic [1023:0] av, bv;
        int n;

        $display("[TB] start");
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", {2'b0, out_valid, in_ready, out1, out2, out3, trunc}, 8'b0001_0000);

        applyStimulus("gt1010", 1024'b1010, 1024'b1001, 4, 1'b1);
        checkOutput("gt1010");

        applyStimulus("eq0110", 1024'b0110, 1024'b0110, 4, 1'b1);
        checkOutput("eq0110");

        applyStimulus("lt1bit", 1024'b0, 1024'b1, 1, 1'b1);
        checkOutput("lt1bit");

        applyStimulus("gt1bit", 1024'b1, 1024'b0, 1, 1'b1);
        checkOutput("gt1bit");

        // Stall the result and throw ignored pairs at the block.
        applyStimulus("hold", 1024'b0011, 1024'b0101, 4, 1'b1);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a        = 1'b1;
            b        = 1'b0;
            in_last  = 1'b1;
            tick();
            chk("hold_stable", {3'b0, in_ready, out1, out2, out3, trunc},
                {3'b0, 1'b0, expQ[0]});
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("hold");

        applyStimulus("trunc32", '0, '0, MAX_BITS, 1'b0);
        checkOutput("trunc32");

        applyStimulus("last32", '0, '0, MAX_BITS, 1'b1);
        checkOutput("last32");

        applyStimulus("limitgt", {992'b0, 32'h8000_0000}, '0, MAX_BITS, 1'b0);
        checkOutput("limitgt");

        // Mid-operand reset must discard the GT already held.
        in_valid = 1'b1;
        a = 1'b1; b = 1'b1; tick();
        a = 1'b1; b = 1'b0; tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", {2'b0, out_valid, in_ready, out1, out2, out3, trunc}, 8'b0001_0000);
        applyStimulus("after_rst", 1024'b0, 1024'b1, 1, 1'b1);
        checkOutput("after_rst");

        // Reset wins over a simultaneous final transfer.
        in_valid = 1'b1; a = 1'b1; b = 1'b0; in_last = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("rst_prio", {2'b0, out_valid, in_ready, out1, out2, out3, trunc}, 8'b0001_0000);

        applyStimulus("order", 1024'b10, 1024'b01, 2, 1'b1);
        checkOutput("order");

        for (int t = 0; t < 12; t++) begin
            av = '0;
            bv = '0;
            av[31:0] = $urandom;
            bv[31:0] = $urandom;
            n = $urandom_range(1, 8);
            applyStimulus("rand", av, bv, n, 1'b1);
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_compare.md
SERIAL_COMPARE -- requirements
Module: serial_compare

Interface
REQ-001 Parameter MAX_BITS SHALL be: default 32, maximum operand length in bits, range 1..1024.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, reset, synchronous and active-high.
REQ-004 Port in_valid SHALL be: input, 1 bit, bit pair a/b/in_last valid.
REQ-005 Port in_ready SHALL be: output, 1 bit, block accepts a bit pair this cycle.
REQ-006 Port a SHALL be: input, 1 bit, current bit of operand A.
REQ-007 Port b SHALL be: input, 1 bit, current bit of operand B.
REQ-008 Port in_last SHALL be: input, 1 bit, final bit pair of the operands.
REQ-009 Port out_valid SHALL be: output, 1 bit, comparison result valid.
REQ-010 Port out_ready SHALL be: input, 1 bit, consumer takes the result.
REQ-011 Port out1 SHALL be: output, 1 bit, A>B.
REQ-012 Port out2 SHALL be: output, 1 bit, A==B.
REQ-013 Port out3 SHALL be: output, 1 bit, A<B.
REQ-014 Port trunc SHALL be: output, 1 bit, result forced by reaching MAX_BITS without in_last.

Function
REQ-015 Block SHALL be a two-state FSM: S_RUN (accept bits) and S_DONE (hold result).
REQ-016 S_RUN behaviour SHALL be: in_ready=1, out_valid=0; in S_DONE: in_ready=0, out_valid=1.
REQ-017 A transfer SHALL occur only when in_valid and in_ready are both 1 on a rising edge; in_valid without in_ready has no effect.
REQ-018 Per transfer (default MSB-first), if no decision is held: a=1,b=0 SHALL set decision GT; a=0,b=1 SHALL set decision LT; equal bits leave it unchanged.
REQ-019 Once GT or LT is held, all later bits of the same operand SHALL be consumed but SHALL NOT change the decision.
REQ-020 A bit counter SHALL count transfers 0..MAX_BITS-1 per operand and SHALL NOT wrap within an operand.
REQ-021 A transfer with in_last=1, or the transfer at count MAX_BITS-1, SHALL move the FSM to S_DONE on that edge.
REQ-022 Latency SHALL be one cycle: the result, including the final bit, appears with out_valid=1 in the cycle after the final transfer.
REQ-023 trunc SHALL be 1 only if the final transfer had in_last=0 at count MAX_BITS-1; in_last=1 at that same count SHALL give trunc=0.
REQ-024 When out_valid=1, exactly one of out1/out2/out3 SHALL be 1 (out2 when no decision is held); when out_valid=0, out1, out2, out3 and trunc SHALL all be 0.
REQ-025 In S_DONE, outputs SHALL be held stable while out_ready=0, for any number of cycles.
REQ-026 out_valid and out_ready both 1 on an edge SHALL return the FSM to S_RUN with decision cleared and count 0; the first new bit is accepted no earlier than the following cycle.
REQ-027 A single-bit operand (in_last=1 on the first transfer) SHALL be legal and SHALL produce the 1-bit comparison.

Reset
REQ-028 rst=1 on an edge SHALL force S_RUN, count 0, decision cleared, out_valid=0, out1=out2=out3=trunc=0 and in_ready=1 from the next cycle.
REQ-029 Reset SHALL take priority over any simultaneous transfer or result handshake, and reset mid-operand SHALL discard all accumulated bits.

Configuration
REQ-030 With macro SERIAL_CMP_LSB_FIRST_EN defined, bits SHALL arrive LSB-first: every differing bit overwrites the decision (a=1,b=0 gives GT; a=0,b=1 gives LT), so the last differing bit wins.
REQ-031 Without SERIAL_CMP_LSB_FIRST_EN, REQ-018/REQ-019 MSB-first first-difference behaviour SHALL apply; all other behaviour is identical in both builds.

Verification
REQ-032 Default build, A=1010, B=1001 MSB-first, in_last on the 4th pair -> out_valid=1 the cycle after, out1=1, out2=0, out3=0, trunc=0.
REQ-033 Default build, A=B=0110 -> out2=1; single pair a=0,b=1 with in_last=1 -> out3=1 one cycle later.
REQ-034 Hold out_ready=0 for 3 cycles after a result -> outputs stable, in_ready=0, extra in_valid pulses ignored; out_ready=1 -> in_ready=1 the next cycle.
REQ-035 MAX_BITS=32, 32 equal pairs with in_last=0 -> out2=1, trunc=1; repeat with in_last=1 on pair 32 -> trunc=0.
REQ-036 rst=1 after 2 pairs A=11, B=10, then A=0, B=1 with in_last -> out3=1; no trace of the discarded GT decision.
REQ-037 Pairs (a,b)=(1,0) then (0,1): with SERIAL_CMP_LSB_FIRST_EN (A=1, B=2) -> out3=1; without it (A=2, B=1) -> out1=1.
